// File: rtl/game_referee.sv
// Tic Tac Toe win/draw referee: scans one board line per clock and holds a registered verdict.
// Optional build macro REFEREE_SNAPSHOT_EN captures the board at move acceptance instead of reading it live.
module game_referee #(
  parameter logic [1:0] P0_CODE = 2'b01,
  parameter logic [1:0] P1_CODE = 2'b10
) (
  input  logic        clk,
  input  logic        globalReset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [17:0] board,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  win_signal,
  output logic [3:0]  win_line
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  win_signal_q, win_signal_d;
  logic [3:0]  win_line_q, win_line_d;
  logic [17:0] scan_board;

  // Cell indices of each line packed as {c2, c1, c0}, in scan order.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'h210;
      3'd1:    return 12'h543;
      3'd2:    return 12'h876;
      3'd3:    return 12'h630;
      3'd4:    return 12'h741;
      3'd5:    return 12'h852;
      3'd6:    return 12'h840;
      default: return 12'h642;
    endcase
  endfunction

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (b[2*i +: 2] != P0_CODE && b[2*i +: 2] != P1_CODE) full = 1'b0;
    end
    return full;
  endfunction

`ifdef REFEREE_SNAPSHOT_EN
  logic [17:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (state_q == IDLE && move_valid && !new_game) snap_d = board;
  end

  // Data-only register: contents are don't-care until a move is accepted.
  always_ff @(posedge clk) snap_q <= snap_d;

  assign scan_board = snap_q;
`else
  assign scan_board = board;
`endif

  logic [11:0] cells;
  logic [1:0]  c0, c1, c2;
  logic        p0_line, p1_line;

  always_comb begin
    cells   = line_cells(idx_q);
    c0      = cell_at(scan_board, cells[3:0]);
    c1      = cell_at(scan_board, cells[7:4]);
    c2      = cell_at(scan_board, cells[11:8]);
    p0_line = (c0 == P0_CODE) && (c1 == P0_CODE) && (c2 == P0_CODE);
    p1_line = (c0 == P1_CODE) && (c1 == P1_CODE) && (c2 == P1_CODE);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    game_over_d  = game_over_q;
    win_signal_d = win_signal_q;
    win_line_d   = win_line_q;
    if (new_game) begin
      state_d      = IDLE;
      idx_d        = 3'd0;
      busy_d       = 1'b0;
      game_over_d  = 1'b0;
      win_signal_d = 2'b00;
      win_line_d   = 4'hF;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            state_d = SCAN;
            idx_d   = 3'd0;
            busy_d  = 1'b1;
          end
        end
        SCAN: begin
          // The verdict is written straight from 00 to its final code in one update.
          if (p0_line || p1_line) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            game_over_d  = 1'b1;
            win_signal_d = p0_line ? 2'b01 : 2'b10;
            win_line_d   = {1'b0, idx_q};
            idx_d        = 3'd0;
          end else if (idx_q == 3'd7) begin
            busy_d = 1'b0;
            idx_d  = 3'd0;
            if (board_full(scan_board)) begin
              state_d      = DONE;
              game_over_d  = 1'b1;
              win_signal_d = 2'b11;
              win_line_d   = 4'hF;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      win_signal_q <= 2'b00;
      win_line_q   <= 4'hF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      win_signal_q <= win_signal_d;
      win_line_q   <= win_line_d;
    end
  end

  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign win_signal = win_signal_q;
  assign win_line   = win_line_q;

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: directed boards push expected verdicts, a monitor checks each scan end.
module tb_game_referee;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        new_game;
  logic        move_valid;
  logic [17:0] board;
  logic        busy;
  logic        game_over;
  logic [1:0]  win_signal;
  logic [3:0]  win_line;

  game_referee dut (
    .clk        (clk),
    .globalReset(globalReset),
    .new_game   (new_game),
    .move_valid (move_valid),
    .board      (board),
    .busy       (busy),
    .game_over  (game_over),
    .win_signal (win_signal),
    .win_line   (win_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ws;
    logic [3:0] wl;
    logic       go;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bcnt     = 0;
  logic bprev    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a scan ends when busy falls; its verdict is compared with the queue head.
  always @(negedge clk) begin
    if (globalReset) begin
      bcnt  = 0;
      bprev = 1'b0;
    end else begin
      if (busy) begin
        bcnt++;
        chk("ws_quiet_while_busy", {30'd0, win_signal}, 32'd0);
      end else if (bprev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_scan_end: ws=%0h wl=%0h with empty scoreboard", win_signal, win_line);
        end else begin
          e = sb.pop_front();
          chk("win_signal", {30'd0, win_signal}, {30'd0, e.ws});
          chk("win_line", {28'd0, win_line}, {28'd0, e.wl});
          chk("game_over", {31'd0, game_over}, {31'd0, e.go});
          chk("busy_cycles", bcnt, e.lat);
        end
        bcnt = 0;
      end
      bprev = busy;
    end
  end

  task automatic pulse_move();
    @(negedge clk) move_valid = 1'b1;
    @(negedge clk) move_valid = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic run_case(input string name, input logic [17:0] b, input logic [1:0] ws,
                          input logic [3:0] wl, input logic go, input int lat);
    exp_t x;
    board = b;
    x.ws = ws; x.wl = wl; x.go = go; x.lat = lat;
    sb.push_back(x);
    pulse_move();
    wait_drain(name);
  endtask

  initial begin
    globalReset = 1'b1;
    new_game    = 1'b0;
    move_valid  = 1'b0;
    board       = 18'h0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_game_over", {31'd0, game_over}, 32'd0);
    chk("rst_win_signal", {30'd0, win_signal}, 32'd0);
    chk("rst_win_line", {28'd0, win_line}, 32'hF);
    @(negedge clk) globalReset = 1'b0;

    // Player 0 row 0: verdict one cycle after the move.
    run_case("p0_row0", 18'h00015, 2'b01, 4'd0, 1'b1, 1);

    // Held verdict ignores further moves.
    pulse_move();
    repeat (3) @(negedge clk);
    chk("done_hold_busy", {31'd0, busy}, 32'd0);
    chk("done_hold_ws", {30'd0, win_signal}, 32'd1);
    chk("done_hold_go", {31'd0, game_over}, 32'd1);

    // new_game beats a simultaneous move.
    @(negedge clk) begin new_game = 1'b1; move_valid = 1'b1; end
    @(negedge clk) begin new_game = 1'b0; move_valid = 1'b0; end
    chk("clear_ws", {30'd0, win_signal}, 32'd0);
    chk("clear_wl", {28'd0, win_line}, 32'hF);
    chk("clear_go", {31'd0, game_over}, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("clear_no_scan", {31'd0, busy}, 32'd0);

    run_case("p1_anti_diag", 18'h02225, 2'b10, 4'd7, 1'b1, 8);
    pulse_new_game();
    run_case("p0_col1", 18'h04104, 2'b01, 4'd4, 1'b1, 5);
    pulse_new_game();
    run_case("both_lines", 18'h2A015, 2'b01, 4'd0, 1'b1, 1);
    pulse_new_game();
    run_case("draw", 18'h16A59, 2'b11, 4'hF, 1'b1, 8);
    pulse_new_game();

    // Non-terminal move with a second move during busy that must not queue.
    begin
      exp_t x;
      board = 18'h00001;
      x.ws = 2'b00; x.wl = 4'hF; x.go = 1'b0; x.lat = 8;
      sb.push_back(x);
      pulse_move();
      repeat (2) @(negedge clk);
      pulse_move();
      wait_drain("non_terminal");
      repeat (4) @(negedge clk);
      chk("nt_idle_busy", {31'd0, busy}, 32'd0);
      chk("nt_idle_ws", {30'd0, win_signal}, 32'd0);
    end

    // Board cleared right after acceptance.
    begin
      exp_t x;
      board = 18'h00015;
`ifdef REFEREE_SNAPSHOT_EN
      x.ws = 2'b01; x.wl = 4'd0; x.go = 1'b1; x.lat = 1;
`else
      x.ws = 2'b00; x.wl = 4'hF; x.go = 1'b0; x.lat = 8;
`endif
      sb.push_back(x);
      @(negedge clk) move_valid = 1'b1;
      @(posedge clk);
      #1 begin move_valid = 1'b0; board = 18'h0; end
      wait_drain("snapshot");
      pulse_new_game();
    end

    // Asynchronous reset in the middle of a scan.
    board = 18'h00001;
    pulse_move();
    @(posedge clk);
    #3 globalReset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_go", {31'd0, game_over}, 32'd0);
    chk("arst_ws", {30'd0, win_signal}, 32'd0);
    chk("arst_wl", {28'd0, win_line}, 32'hF);
    repeat (2) @(negedge clk);
    globalReset = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst_no_verdict", {30'd0, win_signal}, 32'd0);
    chk("arst_stays_idle", {31'd0, busy}, 32'd0);

    // Accepts a new move normally after reset.
    run_case("after_reset", 18'h00015, 2'b01, 4'd0, 1'b1, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
